// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// Frame controller placed after the UART byte receiver. It parses the byte
// stream [SOF][LEN][PAYLOAD x LEN][CHK], buffers the payload and only releases
// frames whose XOR checksum matches, as a valid/ready byte stream.
// Errors (checksum, length, inter-byte timeout, overrun during drain) are
// reported as a one-cycle frm_err pulse with a sticky err_code.
// Optional feature macro: FRAME_STATS_EN adds good_cnt/err_cnt statistics.
module uart_rx_frame_ctrl #(
    parameter logic [7:0] SOF_BYTE    = 8'hA5,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 1200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_byte_valid,
    output logic [7:0]  frm_data,
    output logic        frm_valid,
    input  logic        frm_ready,
    output logic        frm_last,
    output logic        frm_err,
    output logic [1:0]  err_code
`ifdef FRAME_STATS_EN
    ,
    output logic [15:0] good_cnt,
    output logic [15:0] err_cnt
`endif
);

    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [1:0] ERR_CHECKSUM = 2'd0;
    localparam logic [1:0] ERR_LENGTH   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_OVERRUN  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_DRAIN
    } state_t;

    state_t          state;
    logic [IW-1:0]   len;
    logic [IW-1:0]   wr_idx;
    logic [IW-1:0]   rd_idx;
    logic [7:0]      csum;
    logic [TW-1:0]   tmo_cnt;
    logic [7:0]      pay_mem [0:MAX_LEN-1];

    logic [IW-1:0]   last_idx;
    logic [IW-1:0]   rd_next;
    logic            len_bad;
    logic            csum_ok;

    assign last_idx = len - IW'(1);
    assign rd_next  = rd_idx + IW'(1);
    assign len_bad  = (rx_byte == 8'd0) || (rx_byte > MAX_LEN_B);
    assign csum_ok  = (rx_byte == csum);

    // Payload buffer: written once per payload strobe, no reset needed since
    // entries are always written before they are read.
    always_ff @(posedge clk) begin
        if (state == ST_PAYLOAD && rx_byte_valid) begin
            pay_mem[wr_idx[AW-1:0]] <= rx_byte;
        end
    end

    // Frame FSM: parsing, checksum, timeout, drain handshake and error pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            len       <= '0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            csum      <= '0;
            tmo_cnt   <= '0;
            frm_data  <= '0;
            frm_valid <= 1'b0;
            frm_last  <= 1'b0;
            frm_err   <= 1'b0;
            err_code  <= '0;
        end else begin
            frm_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tmo_cnt <= '0;
                    if (rx_byte_valid && rx_byte == SOF_BYTE) begin
                        state <= ST_LEN;
                    end
                end

                ST_LEN, ST_PAYLOAD, ST_CHK: begin
                    if (rx_byte_valid) begin
                        tmo_cnt <= '0;
                        case (state)
                            ST_LEN: begin
                                if (len_bad) begin
                                    frm_err  <= 1'b1;
                                    err_code <= ERR_LENGTH;
                                    state    <= ST_IDLE;
                                end else begin
                                    len    <= rx_byte[IW-1:0];
                                    csum   <= rx_byte;
                                    wr_idx <= '0;
                                    state  <= ST_PAYLOAD;
                                end
                            end
                            ST_PAYLOAD: begin
                                csum   <= csum ^ rx_byte;
                                wr_idx <= wr_idx + IW'(1);
                                if (wr_idx == last_idx) begin
                                    state <= ST_CHK;
                                end
                            end
                            ST_CHK: begin
                                if (csum_ok) begin
                                    rd_idx    <= '0;
                                    frm_data  <= pay_mem[0];
                                    frm_valid <= 1'b1;
                                    frm_last  <= (len == IW'(1));
                                    state     <= ST_DRAIN;
                                end else begin
                                    frm_err  <= 1'b1;
                                    err_code <= ERR_CHECKSUM;
                                    state    <= ST_IDLE;
                                end
                            end
                            default: ;
                        endcase
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo_cnt  <= '0;
                        frm_err  <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                        state    <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                ST_DRAIN: begin
                    if (rx_byte_valid) begin
                        frm_err  <= 1'b1;
                        err_code <= ERR_OVERRUN;
                    end
                    if (frm_valid && frm_ready) begin
                        if (frm_last) begin
                            frm_valid <= 1'b0;
                            frm_last  <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            rd_idx   <= rd_next;
                            frm_data <= pay_mem[rd_next[AW-1:0]];
                            frm_last <= (rd_next == last_idx);
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FRAME_STATS_EN
    // Saturating counters of accepted frames and reported errors.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            good_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (state == ST_CHK && rx_byte_valid && csum_ok && good_cnt != 16'hFFFF) begin
                good_cnt <= good_cnt + 16'd1;
            end
            if (frm_err && err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl
// Self-checking bench for uart_rx_frame_ctrl: directed frames for the key
// cases followed by randomized frames. Expected payload beats and error
// events are derived from the frame contents and queued ahead of time.
// Compile with FRAME_STATS_EN defined to also check the statistics counters.
module tb_uart_rx_frame_ctrl;

    localparam int         MAX_LEN = 16;
    localparam int         TMO     = 1200;
    localparam logic [7:0] SOF     = 8'hA5;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_byte;
    logic        rx_byte_valid;
    logic [7:0]  frm_data;
    logic        frm_valid;
    logic        frm_ready;
    logic        frm_last;
    logic        frm_err;
    logic [1:0]  err_code;
`ifdef FRAME_STATS_EN
    logic [15:0] good_cnt;
    logic [15:0] err_cnt;
`endif

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        logic [1:0] code;
        int         cyc;
    } err_t;

    beat_t exp_q[$];
    err_t  err_q[$];
    int    xfer_cyc[$];

    int checks;
    int errors;
    int cyc;
    int last_strobe;
    int ready_mode;
    int good_model;
    int err_model;

    uart_rx_frame_ctrl #(
        .SOF_BYTE   (SOF),
        .MAX_LEN    (MAX_LEN),
        .TIMEOUT_CYC(TMO)
    ) dut (
`ifdef FRAME_STATS_EN
        .good_cnt     (good_cnt),
        .err_cnt      (err_cnt),
`endif
        .clk          (clk),
        .reset        (reset),
        .rx_byte      (rx_byte),
        .rx_byte_valid(rx_byte_valid),
        .frm_data     (frm_data),
        .frm_valid    (frm_valid),
        .frm_ready    (frm_ready),
        .frm_last     (frm_last),
        .frm_err      (frm_err),
        .err_code     (err_code)
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Downstream ready: 0 = random, 1 = always ready, 2 = stalled
    initial begin
        frm_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       frm_ready = ($urandom_range(0, 2) != 0);
                1:       frm_ready = 1'b1;
                default: frm_ready = 1'b0;
            endcase
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Output monitor: transfers, stall stability and error pulses
    initial begin
        logic       stall;
        logic [7:0] sd;
        logic       sl;
        beat_t      b;
        err_t       e;
        stall = 1'b0;
        sd    = '0;
        sl    = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall = 1'b0;
                continue;
            end
            if (stall) begin
                checkOutput("stall_valid", 32'(frm_valid), 32'd1);
                checkOutput("stall_data", 32'(frm_data), 32'(sd));
                checkOutput("stall_last", 32'(frm_last), 32'(sl));
            end
            if (frm_valid && frm_ready) begin
                xfer_cyc.push_back(cyc);
                checkOutput("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    b = exp_q.pop_front();
                    checkOutput("data", 32'(frm_data), 32'(b.data));
                    checkOutput("last", 32'(frm_last), 32'(b.last));
                end
            end
            stall = frm_valid && !frm_ready;
            sd    = frm_data;
            sl    = frm_last;
            if (frm_err) begin
                checkOutput("err_expected", 32'(err_q.size() != 0), 32'd1);
                if (err_q.size() != 0) begin
                    e = err_q.pop_front();
                    checkOutput("err_code", 32'(err_code), 32'(e.code));
                    if (e.cyc != 0) begin
                        checkOutput("err_cycle", 32'(cyc), 32'(e.cyc));
                    end
                end
            end
        end
    end

    // Safety net in case some wait is mis-bounded
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, %0d checks so far", checks);
        $fatal(1, "[TB] watchdog");
    end

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one strobe, then leave the line quiet for idle cycles
    task automatic applyStimulus(input logic [7:0] b, input int idle);
        rx_byte       = b;
        rx_byte_valid = 1'b1;
        @(posedge clk);
        #1;
        last_strobe   = cyc;
        rx_byte_valid = 1'b0;
        idleCycles(idle);
    endtask

    task automatic pushBeat(input logic [7:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        exp_q.push_back(b);
    endtask

    task automatic pushErr(input logic [1:0] code, input int at_cyc);
        err_t e;
        e.code = code;
        e.cyc  = at_cyc;
        err_q.push_back(e);
        err_model++;
    endtask

    task automatic waitDrain(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_done", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic doReset();
        reset = 1'b1;
        exp_q.delete();
        err_q.delete();
        good_model = 0;
        err_model  = 0;
    endtask

    // Random frame: 0 good, 1 bad checksum, 2 bad length, 3 timeout
    task automatic sendFrame(input int kind, input int plen, input logic overrun);
        logic [7:0] seq[$];
        logic [7:0] chk;
        int         p;
        if (kind == 2) begin
            applyStimulus(SOF, $urandom_range(0, 3));
            pushErr(2'd1, 0);
            applyStimulus(8'(plen), 1);
            return;
        end
        chk = 8'(plen);
        seq.push_back(SOF);
        seq.push_back(8'(plen));
        for (int i = 0; i < plen; i++) begin
            seq.push_back(8'($urandom));
            chk ^= seq[i + 2];
        end
        if (kind == 3) begin
            p = $urandom_range(0, plen + 1);
            for (int i = 0; i <= p; i++) begin
                applyStimulus(seq[i], (i == p) ? 0 : $urandom_range(0, 3));
            end
            pushErr(2'd2, last_strobe + TMO);
            idleCycles(TMO + 3);
            return;
        end
        for (int i = 0; i < plen + 2; i++) begin
            applyStimulus(seq[i], $urandom_range(0, 3));
        end
        if (kind == 1) begin
            chk ^= 8'($urandom_range(1, 255));
            pushErr(2'd0, 0);
        end else begin
            for (int i = 0; i < plen; i++) begin
                pushBeat(seq[i + 2], (i == plen - 1));
            end
        end
        applyStimulus(chk, 0);
        if (kind == 0) begin
            good_model++;
            if (overrun) begin
                pushErr(2'd3, 0);
                applyStimulus(8'($urandom), 0);
            end
            waitDrain(400);
        end else begin
            idleCycles(1);
        end
    endtask

    // Main sequence
    initial begin
        int chk_cyc;
        int r;
        int plen;
        logic [7:0] stray;

        checks        = 0;
        errors        = 0;
        last_strobe   = 0;
        ready_mode    = 1;
        rx_byte       = '0;
        rx_byte_valid = 1'b0;
        doReset();
        idleCycles(3);
        checkOutput("rst_valid", 32'(frm_valid), 32'd0);
        checkOutput("rst_data", 32'(frm_data), 32'd0);
        checkOutput("rst_last", 32'(frm_last), 32'd0);
        checkOutput("rst_err", 32'(frm_err), 32'd0);
        checkOutput("rst_code", 32'(err_code), 32'd0);
        reset = 1'b0;
        idleCycles(2);

        // Good frame, always ready: three consecutive beats, 1-cycle latency
        xfer_cyc.delete();
        pushBeat(8'h11, 1'b0);
        pushBeat(8'h22, 1'b0);
        pushBeat(8'h33, 1'b1);
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h03, 0);
        applyStimulus(8'h11, 0);
        applyStimulus(8'h22, 0);
        applyStimulus(8'h33, 0);
        applyStimulus(8'h03, 0);
        chk_cyc = last_strobe;
        good_model++;
        waitDrain(20);
        checkOutput("t1_beats", 32'(xfer_cyc.size()), 32'd3);
        if (xfer_cyc.size() == 3) begin
            checkOutput("t1_first_cyc", 32'(xfer_cyc[0]), 32'(chk_cyc));
            checkOutput("t1_last_cyc", 32'(xfer_cyc[2]), 32'(chk_cyc + 2));
        end

        // Bad checksum, then a one-byte frame
        pushErr(2'd0, 0);
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h03, 0);
        applyStimulus(8'h11, 0);
        applyStimulus(8'h22, 0);
        applyStimulus(8'h33, 0);
        applyStimulus(8'h04, 3);
        pushBeat(8'h7E, 1'b1);
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h7E, 0);
        applyStimulus(8'h7F, 0);
        good_model++;
        waitDrain(20);

        // Stray bytes, zero length and oversize length
        applyStimulus(8'h00, 1);
        applyStimulus(8'hFF, 1);
        pushErr(2'd1, 0);
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h00, 2);
        pushErr(2'd1, 0);
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h11, 3);
        checkOutput("t3_code_held", 32'(err_code), 32'd1);

        // Timeout fires exactly TMO cycles after the last strobe
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h02, 0);
        applyStimulus(8'hAA, 0);
        pushErr(2'd2, last_strobe + TMO);
        idleCycles(TMO + 3);
        checkOutput("t4_code_held", 32'(err_code), 32'd2);
        checkOutput("t4_err_low", 32'(frm_err), 32'd0);

        // Strobes landing on the last allowed cycle beat the timeout
        pushBeat(8'hAA, 1'b0);
        pushBeat(8'hBB, 1'b1);
        applyStimulus(8'hA5, TMO - 1);
        applyStimulus(8'h02, TMO - 1);
        applyStimulus(8'hAA, TMO - 1);
        applyStimulus(8'hBB, TMO - 1);
        applyStimulus(8'h13, 0);
        good_model++;
        waitDrain(20);

        // Stalled drain with an overrun strobe, then random ready
        ready_mode = 2;
        idleCycles(2);
        pushBeat(8'hC1, 1'b0);
        pushBeat(8'hC2, 1'b0);
        pushBeat(8'hC3, 1'b1);
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h03, 0);
        applyStimulus(8'hC1, 0);
        applyStimulus(8'hC2, 0);
        applyStimulus(8'hC3, 0);
        applyStimulus(8'hC3, 0);
        good_model++;
        pushErr(2'd3, 0);
        applyStimulus(8'h5A, 10);
        checkOutput("t5_stalled_valid", 32'(frm_valid), 32'd1);
        checkOutput("t5_stalled_data", 32'(frm_data), 32'hC1);
        ready_mode = 0;
        waitDrain(200);

        // Reset in the middle of a payload
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h04, 0);
        applyStimulus(8'h11, 0);
        applyStimulus(8'h22, 0);
        doReset();
        #1;
        checkOutput("t6p_code", 32'(err_code), 32'd0);
        checkOutput("t6p_valid", 32'(frm_valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idleCycles(2);

        // Reset in the middle of a stalled drain
        ready_mode = 2;
        idleCycles(2);
        pushBeat(8'h10, 1'b0);
        pushBeat(8'h20, 1'b1);
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h02, 0);
        applyStimulus(8'h10, 0);
        applyStimulus(8'h20, 0);
        applyStimulus(8'h32, 2);
        checkOutput("t6d_valid_pre", 32'(frm_valid), 32'd1);
        checkOutput("t6d_data_pre", 32'(frm_data), 32'h10);
        doReset();
        #1;
        checkOutput("t6d_valid", 32'(frm_valid), 32'd0);
        checkOutput("t6d_data", 32'(frm_data), 32'd0);
        checkOutput("t6d_last", 32'(frm_last), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ready_mode = 1;
        idleCycles(2);
        sendFrame(0, 5, 1'b0);

        // Randomized frames
        ready_mode = 0;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                stray = 8'($urandom);
                if (stray == SOF) stray = 8'h00;
                applyStimulus(stray, $urandom_range(0, 2));
            end
            r    = $urandom_range(0, 9);
            plen = $urandom_range(1, MAX_LEN);
            if (r <= 5) begin
                sendFrame(0, plen, (r == 5));
            end else if (r == 6) begin
                sendFrame(1, plen, 1'b0);
            end else if (r == 7) begin
                sendFrame(2, ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255), 1'b0);
            end else if (r == 8) begin
                sendFrame(3, plen, 1'b0);
            end else begin
                sendFrame(0, MAX_LEN, 1'b0);
            end
        end

        idleCycles(20);
        checkOutput("end_beats_left", 32'(exp_q.size()), 32'd0);
        checkOutput("end_errs_left", 32'(err_q.size()), 32'd0);
`ifdef FRAME_STATS_EN
        checkOutput("good_cnt", 32'(good_cnt), 32'(good_model));
        checkOutput("err_cnt", 32'(err_cnt), 32'(err_model));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
